// File: rtl/axis_sample_repack.sv
// AXI4-Stream repacker between MSB-aligned lane samples and dense packed samples, with a two-entry skid stage.
// Optional saturating clip counter, built when AXIS_REPACK_CLIPCNT_EN is defined.
module axis_sample_repack #(
    parameter int    NSAMP        = 8,
    parameter int    NBITS        = 12,
    parameter int    LANEBITS     = 16,
    parameter string MODE         = "UNPACK",
    parameter int    CLIPCNT_BITS = 32,
    localparam int   LANE_W       = NSAMP * LANEBITS,
    localparam int   PACK_W       = NSAMP * NBITS,
    localparam int   IN_W         = (MODE == "UNPACK") ? LANE_W : PACK_W,
    localparam int   OUT_W        = (MODE == "UNPACK") ? PACK_W : LANE_W
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [IN_W-1:0]         s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [OUT_W-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    clip_clear_i,
    output logic [CLIPCNT_BITS-1:0] clip_count_o
);

    localparam int PAD       = LANEBITS - NBITS;
    localparam bit IS_UNPACK = (MODE == "UNPACK");

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               s_ready_r;
    logic               m_valid_r;
    logic [OUT_W-1:0]   out_r;
    logic [OUT_W-1:0]   skid_r;
    logic               accept_s;
    logic               load_out_in_s;
    logic               load_out_skid_s;
    logic               load_skid_s;
    logic [PACK_W-1:0]  in_samp_s;
    logic [OUT_W-1:0]   conv_s;

    // in_samp_s always holds the beat in NBITS space, whichever direction is built
    generate
        if (IS_UNPACK) begin : g_unpack
            for (genvar i = 0; i < NSAMP; i++) begin : g_lane
                assign in_samp_s[NBITS*i +: NBITS] = s_axis_tdata[LANEBITS*i + PAD +: NBITS];
            end
            if (PAD > 0) begin : g_pad
                logic [NSAMP*PAD-1:0] lane_pad_unused_s;
                for (genvar i = 0; i < NSAMP; i++) begin : g_drop
                    assign lane_pad_unused_s[PAD*i +: PAD] = s_axis_tdata[LANEBITS*i +: PAD];
                end
            end
            assign conv_s = in_samp_s;
        end else begin : g_pack
            assign in_samp_s = s_axis_tdata;
            for (genvar i = 0; i < NSAMP; i++) begin : g_lane
                if (PAD > 0) begin : g_padded
                    assign conv_s[LANEBITS*i +: LANEBITS] = {in_samp_s[NBITS*i +: NBITS], {PAD{1'b0}}};
                end else begin : g_pass
                    assign conv_s[LANEBITS*i +: LANEBITS] = in_samp_s[NBITS*i +: NBITS];
                end
            end
        end
    endgenerate

    assign accept_s      = s_axis_tvalid & s_ready_r;
    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = out_r;

    // Storage FSM: next state and which register loads on this edge
    always_comb begin
        state_s         = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_s       = ST_ONE;
                    load_out_in_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && m_axis_tready) begin
                    state_s       = ST_ONE;
                    load_out_in_s = 1'b1;
                end else if (accept_s) begin
                    state_s     = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (m_axis_tready) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // s_ready_r is low here, so no beat can arrive in this state
                if (m_axis_tready) begin
                    state_s         = ST_ONE;
                    load_out_skid_s = 1'b1;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State, registered handshake flags and the two data registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r   <= ST_EMPTY;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            out_r     <= {OUT_W{1'b0}};
            skid_r    <= {OUT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            s_ready_r <= (state_s != ST_TWO);
            m_valid_r <= (state_s != ST_EMPTY);
            if (load_out_in_s) begin
                out_r <= conv_s;
            end else if (load_out_skid_s) begin
                out_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= conv_s;
            end
        end
    end

`ifdef AXIS_REPACK_CLIPCNT_EN
    localparam int                     CW        = $clog2(NSAMP + 1);
    localparam int                     SUM_W     = CLIPCNT_BITS + CW;
    localparam logic [NBITS-1:0]       SMIN_C    = NBITS'(1'b1) << (NBITS - 1);
    localparam logic [NBITS-1:0]       SMAX_C    = ~SMIN_C;
    localparam logic [CLIPCNT_BITS-1:0] CNT_MAX_C = {CLIPCNT_BITS{1'b1}};

    logic [CW-1:0]           clip_beat_s;
    logic [CLIPCNT_BITS-1:0] clip_next_s;
    logic [CLIPCNT_BITS-1:0] clip_cnt_r;

    function automatic logic [CW-1:0] beat_clips(input logic [PACK_W-1:0] samp);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < NSAMP; i++) begin
            if ((samp[NBITS*i +: NBITS] == SMIN_C) || (samp[NBITS*i +: NBITS] == SMAX_C)) begin
                n = n + CW'(1'b1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic [CLIPCNT_BITS-1:0] sat_add(input logic [CLIPCNT_BITS-1:0] base,
                                                        input logic [CW-1:0]           inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX_C)) begin
            return CNT_MAX_C;
        end else begin
            return sum[CLIPCNT_BITS-1:0];
        end
    endfunction

    assign clip_beat_s = beat_clips(in_samp_s);

    // A clear that coincides with an accept restarts the count from that beat
    always_comb begin
        clip_next_s = clip_cnt_r;
        if (accept_s) begin
            if (clip_clear_i) begin
                clip_next_s = sat_add({CLIPCNT_BITS{1'b0}}, clip_beat_s);
            end else begin
                clip_next_s = sat_add(clip_cnt_r, clip_beat_s);
            end
        end else if (clip_clear_i) begin
            clip_next_s = {CLIPCNT_BITS{1'b0}};
        end else begin
            clip_next_s = clip_cnt_r;
        end
    end

    // Clip counter register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            clip_cnt_r <= {CLIPCNT_BITS{1'b0}};
        end else begin
            clip_cnt_r <= clip_next_s;
        end
    end

    assign clip_count_o = clip_cnt_r;
`else
    logic clip_clear_unused_s;

    assign clip_clear_unused_s = clip_clear_i;
    assign clip_count_o        = {CLIPCNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_axis_sample_repack.sv
// Directed bench for axis_sample_repack: unpack mapping, backpressure, reset, clip counter,
// and a PACK->UNPACK round trip of random beats.
`timescale 1ns/1ps
module tb_axis_sample_repack;

`ifdef AXIS_REPACK_CLIPCNT_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;

    logic [127:0] s1_tdata;
    logic         s1_tvalid;
    logic         s1_tready;
    logic [95:0]  m1_tdata;
    logic         m1_tvalid;
    logic         m1_tready;
    logic         clr1;
    logic [3:0]   cnt1;

    logic [95:0]  s2_tdata;
    logic         s2_tvalid;
    logic         s2_tready;
    logic [127:0] m2_tdata;
    logic         m2_tvalid;
    logic         m2_tready;
    logic [95:0]  m3_tdata;
    logic         m3_tvalid;
    logic         m3_tready;
    logic         clr_rt;
    logic [31:0]  clip2_unused;
    logic [31:0]  clip3_unused;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    axis_sample_repack #(.NSAMP(8), .NBITS(12), .LANEBITS(16), .MODE("UNPACK"), .CLIPCNT_BITS(4)) u_unpack1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .clip_clear_i(clr1), .clip_count_o(cnt1)
    );

    axis_sample_repack #(.NSAMP(8), .NBITS(12), .LANEBITS(16), .MODE("PACK"), .CLIPCNT_BITS(32)) u_pack2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
        .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
        .clip_clear_i(clr_rt), .clip_count_o(clip2_unused)
    );

    axis_sample_repack #(.NSAMP(8), .NBITS(12), .LANEBITS(16), .MODE("UNPACK"), .CLIPCNT_BITS(32)) u_unpack3 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(m2_tdata), .s_axis_tvalid(m2_tvalid), .s_axis_tready(m2_tready),
        .m_axis_tdata(m3_tdata), .m_axis_tvalid(m3_tvalid), .m_axis_tready(m3_tready),
        .clip_clear_i(clr_rt), .clip_count_o(clip3_unused)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // round-trip scoreboard, sampled on the falling edge
    logic        rt_en = 1'b0;
    logic [95:0] exp_q[$];
    logic [95:0] rt_e;
    int          n_rx   = 0;
    int          t_acc0 = -1;
    int          t_rx0  = -1;
    int          t_rxl  = -1;

    initial begin
        forever begin
            @(negedge aclk);
            if (rt_en) begin
                if (s2_tvalid && s2_tready) begin
                    exp_q.push_back(s2_tdata);
                    if (t_acc0 < 0) t_acc0 = cyc;
                end
                if (m3_tvalid && m3_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("rt_extra_beat", 128'd1, 128'd0);
                    end else begin
                        rt_e = exp_q.pop_front();
                        chk("rt_data", m3_tdata, rt_e);
                    end
                    n_rx++;
                    if (t_rx0 < 0) t_rx0 = cyc;
                    t_rxl = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [127:0] lanes;
    logic [95:0]  expd;
    logic [11:0]  smp;
    logic [3:0]   nib;
    logic [127:0] bp_l[3];
    logic [95:0]  bp_e[3];
    logic [11:0]  clip_samp[8] = '{12'h7FF, 12'h800, 12'h000, 12'h005, 12'h7FF, 12'h001, 12'h002, 12'h003};
    int           exp_cl[7]    = '{3, 3, 6, 9, 12, 15, 15};
    logic         acc;

    initial begin
        aresetn   = 1'b0;
        s1_tdata  = 128'd0;
        s1_tvalid = 1'b0;
        m1_tready = 1'b0;
        clr1      = 1'b0;
        s2_tdata  = 96'd0;
        s2_tvalid = 1'b0;
        m3_tready = 1'b0;
        clr_rt    = 1'b0;

        // reset state and ready rising one edge after release
        repeat (3) step();
        chk("rst_mvalid", m1_tvalid, 128'd0);
        chk("rst_sready", s1_tready, 128'd0);
        chk("rst_mdata", m1_tdata, 128'd0);
        chk("rst_clip", cnt1, 128'd0);
        aresetn = 1'b1;
        chk("sready_before_edge", s1_tready, 128'd0);
        step();
        chk("sready_after_edge", s1_tready, 128'd1);
        chk("idle_mvalid", m1_tvalid, 128'd0);

        // unpack mapping, three patterns
        m1_tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                case (p)
                    0: begin smp = 12'h100 + 12'(i); nib = 4'hF; end
                    1: begin smp = 12'hA50 + 12'(i * 37); nib = 4'h5; end
                    default: begin smp = (i % 2 == 1) ? 12'hFFF : 12'h000; nib = 4'hA; end
                endcase
                lanes[16*i +: 16] = {smp, nib};
                expd[12*i +: 12]  = smp;
            end
            s1_tdata  = lanes;
            s1_tvalid = 1'b1;
            chk("unpack_prelat_valid", m1_tvalid, 128'd0);
            step();
            chk("unpack_valid", m1_tvalid, 128'd1);
            chk("unpack_data", m1_tdata, expd);
            s1_tvalid = 1'b0;
            step();
            chk("unpack_drained", m1_tvalid, 128'd0);
        end

        // backpressure: A in OUT, B in SKID, C held off, then drain in order
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                smp = 12'h0A0 + 12'(b * 16) + 12'(i);
                bp_l[b][16*i +: 16] = {smp, 4'(i)};
                bp_e[b][12*i +: 12] = smp;
            end
        end
        m1_tready = 1'b0;
        s1_tdata  = bp_l[0];
        s1_tvalid = 1'b1;
        step();
        chk("bp_A_valid", m1_tvalid, 128'd1);
        chk("bp_A_sready", s1_tready, 128'd1);
        chk("bp_A_data", m1_tdata, bp_e[0]);
        s1_tdata = bp_l[1];
        step();
        chk("bp_B_sready_low", s1_tready, 128'd0);
        chk("bp_B_out_holds_A", m1_tdata, bp_e[0]);
        s1_tdata = bp_l[2];
        step();
        chk("bp_hold_sready", s1_tready, 128'd0);
        chk("bp_hold_data", m1_tdata, bp_e[0]);
        m1_tready = 1'b1;
        step();
        chk("bp_skid_to_out", m1_tdata, bp_e[1]);
        chk("bp_sready_back", s1_tready, 128'd1);
        step();
        chk("bp_C_out", m1_tdata, bp_e[2]);
        chk("bp_C_valid", m1_tvalid, 128'd1);
        s1_tvalid = 1'b0;
        step();
        chk("bp_empty", m1_tvalid, 128'd0);

        // reset while two beats are held
        m1_tready = 1'b0;
        s1_tdata  = bp_l[0];
        s1_tvalid = 1'b1;
        step();
        s1_tdata = bp_l[1];
        step();
        chk("rmid_in_two", s1_tready, 128'd0);
        s1_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("rmid_mvalid_now", m1_tvalid, 128'd0);
        chk("rmid_sready_now", s1_tready, 128'd0);
        step();
        aresetn = 1'b1;
        step();
        chk("rmid_sready_rise", s1_tready, 128'd1);
        m1_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rmid_no_stale", m1_tvalid, 128'd0);
            step();
        end

        // clip counter, including clear with a beat and saturation at 4 bits
        for (int i = 0; i < 8; i++) begin
            lanes[16*i +: 16] = {clip_samp[i], 4'h3};
            expd[12*i +: 12]  = clip_samp[i];
        end
        s1_tdata  = lanes;
        s1_tvalid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            clr1 = (k == 1) ? 1'b1 : 1'b0;
            step();
            chk("clip_count", cnt1, CLIP_EN ? 128'(exp_cl[k]) : 128'd0);
            chk("clip_data", m1_tdata, expd);
        end
        clr1      = 1'b0;
        s1_tvalid = 1'b0;
        step();
        chk("clip_hold", cnt1, CLIP_EN ? 128'd15 : 128'd0);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("clip_clear", cnt1, 128'd0);

        // directed PACK check, then random round trip at full rate
        m3_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp = 12'h100 + 12'(i);
            expd[12*i +: 12]  = smp;
            lanes[16*i +: 16] = {smp, 4'h0};
        end
        s2_tdata  = expd;
        s2_tvalid = 1'b1;
        step();
        s2_tvalid = 1'b0;
        chk("pack_valid", m2_tvalid, 128'd1);
        chk("pack_data", m2_tdata, lanes);
        step();
        chk("pack_unpack_data", m3_tdata, expd);
        step();
        chk("pack_drained", m3_tvalid, 128'd0);

        rt_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            s2_tdata  = {$urandom, $urandom, $urandom};
            s2_tvalid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 50 && !acc; w++) begin
                @(negedge aclk);
                acc = s2_tready;
                @(posedge aclk);
                #1;
            end
            if (!acc) begin
                chk("rt_accept_timeout", 128'd0, 128'd1);
                break;
            end
        end
        s2_tvalid = 1'b0;
        for (int w = 0; w < 20 && n_rx < 1000; w++) step();
        step();
        chk("rt_count", 128'(n_rx), 128'd1000);
        chk("rt_fill", 128'(t_rx0 - t_acc0), 128'd2);
        chk("rt_rate", 128'(t_rxl - t_rx0), 128'd999);
        chk("rt_leftover", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_sample_repack.md
# axis_sample_repack

- Parametrised single-clock AXI4-Stream sample repacker between the RFDC sample format (NBITS samples MSB-aligned in LANEBITS-wide lanes) and the dense packed format used by the filter chain (biquad, FIR).
- Direction is selected by parameter, so one block serves ADC→filter and filter→DAC paths.
- Unlike the fixed combinational pack/unpack helpers, it supports any sample and lane width and full tvalid/tready backpressure through a two-entry skid stage.
- It also carries an optional full-scale (clip) sample counter.

## Interface
Parameters:
- NSAMP, 8, samples per beat
- NBITS, 12, significant bits per sample (two's complement); 1 ≤ NBITS ≤ LANEBITS
- LANEBITS, 16, lane width in the lane format
- MODE, "UNPACK", "UNPACK" converts lane→packed; "PACK" converts packed→lane
- CLIPCNT_BITS, 32, clip counter width

Ports:
- aclk  in  1  sole clock
- aresetn  in  1  reset; asynchronous, active-low
- s_axis_tdata  in  IN_W  input beat. IN_W = NSAMP*LANEBITS when MODE="UNPACK", otherwise NSAMP*NBITS.
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- m_axis_tdata  out  OUT_W  output beat. OUT_W is the other of the two widths.
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- clip_clear_i  in  1  synchronous clear of clip counter
- clip_count_o  out  CLIPCNT_BITS  accumulated clipped-sample count

## Operation
- Accept occurs when s_axis_tvalid & s_axis_tready. Emit occurs when m_axis_tvalid & m_axis_tready.
- UNPACK: sample i = s_axis_tdata[LANEBITS*i + (LANEBITS-NBITS) +: NBITS], written to out[NBITS*i +: NBITS]. The low LANEBITS-NBITS bits of each lane are discarded.
- PACK: out[LANEBITS*i +: LANEBITS] = {sample i, (LANEBITS-NBITS) zeros}.
- NBITS == LANEBITS is legal: the conversion becomes a pass-through.
- Storage is an output register (OUT) plus a skid register (SKID). FSM states:
  - EMPTY: OUT invalid.
    - accept → ONE (data into OUT).
  - ONE: OUT valid, SKID empty.
    - accept & m_axis_tready → ONE (OUT reloaded).
    - accept & !m_axis_tready → TWO (data into SKID).
    - no accept & m_axis_tready → EMPTY.
    - otherwise hold.
  - TWO: both registers full.
    - m_axis_tready → ONE (SKID moves to OUT).
    - otherwise hold. No accept is possible in this state.
- s_axis_tready is registered: next value = (next state != TWO).
- Beat order is strictly preserved. No beat is dropped or duplicated. m_axis_tdata is stable while m_axis_tvalid & !m_axis_tready.
- Clip detection is done on accepted input samples (in NBITS space).
  - A sample clips if it equals 2^(NBITS-1)-1 or -2^(NBITS-1).
  - The per-beat clip count (0..NSAMP) is added to clip_count_o, saturating at all-ones.

## Timing
- Reset (aresetn low), asynchronous:
  - state = EMPTY.
  - m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0, clip_count_o = 0.
  - s_axis_tready rises on the first aclk edge after aresetn deasserts.
- Latency: an accept at edge k gives m_axis_tvalid = 1 with that data after edge k; it is emitted at edge k+1 if m_axis_tready is high.
- Throughput: 1 beat/cycle with m_axis_tready held high.
- Backpressure:
  - Stalling in ONE while a beat is accepted drops s_axis_tready after that same edge.
  - In TWO, the edge at which m_axis_tready is high restores s_axis_tready.
- Reset mid-operation: all held beats are discarded, with no partial output.
- Clip counter:
  - Updates at the accept edge (same edge as data capture).
  - clip_clear_i alone: counter = 0 at the next edge.
  - clip_clear_i coinciding with an accept: counter = that beat's count.
  - Saturation: the counter holds all-ones until cleared.

## Configuration
- AXIS_REPACK_CLIPCNT_EN defined: clip detection and counter are implemented as above.
- AXIS_REPACK_CLIPCNT_EN undefined:
  - clip_count_o is tied to 0 and clip_clear_i is ignored.
  - No counter logic is synthesised.
  - Data path and handshake are identical.

## Test plan
- Unpack mapping: NSAMP=8, NBITS=12, LANEBITS=16; input lane i = {12'h100+i, 4'hF}, m_axis_tready=1 → output sample i = 12'h100+i, appearing one cycle after accept; low nibbles discarded.
- Pack round-trip: a PACK instance feeds an UNPACK instance; 1000 random beats → identical sequence out; with tready held high, exactly one beat per cycle after the 2-cycle fill.
- Backpressure: stream beats A,B,C with m_axis_tready low from A's accept → A in OUT, B in SKID, s_axis_tready=0 after B's accept edge; raise m_axis_tready for 3 cycles → A,B,C emitted in order, no loss.
- Reset mid-flight: assert aresetn low while in TWO → m_axis_tvalid=0 immediately; after release, s_axis_tready=1 after one edge; no stale beat emitted.
- Clip count (macro defined): beat with samples {2047, -2048, 0, 5, 2047, 1, 2, 3} → clip_count_o += 3; clip_clear_i together with that beat → clip_count_o=3; CLIPCNT_BITS=4 with 6 such beats → saturates at 15.
- Macro undefined: the same clip stimulus → clip_count_o stays 0; data output unchanged versus the macro-defined build.
